// File: rtl/pwm_reg_pkg.sv
// PWM register file shared definitions.
// Address map bases, CTRL/STATUS bit positions and read latency.
package pwm_reg_pkg;

    localparam logic [6:0] EN_OUT_BASE   = 7'h00;
    localparam logic [6:0] EN_PWM_BASE   = 7'h10;
    localparam logic [6:0] DUTY_BASE     = 7'h20;
    localparam logic [6:0] LOCK_SPAN_END = 7'h5F;
    localparam logic [6:0] CTRL_ADDR     = 7'h7E;
    localparam logic [6:0] STATUS_ADDR   = 7'h7F;

    localparam int CTRL_LOCK_BIT   = 0;
    localparam int CTRL_FORCE_BIT  = 1;
    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    localparam int RD_LATENCY = 1;

    function automatic logic [7:0] status_byte(
        input logic err_bit,
        input logic pend_bit
    );
        logic [7:0] s;
        s = '0;
        s[STATUS_ERR_BIT]  = err_bit;
        s[STATUS_PEND_BIT] = pend_bit;
        return s;
    endfunction

    function automatic logic [7:0] ctrl_byte(input logic lock_bit);
        logic [7:0] s;
        s = '0;
        s[CTRL_LOCK_BIT] = lock_bit;
        return s;
    endfunction

endpackage

// File: rtl/pwm_duty_bank.sv
// Duty shadow/active storage for the PWM register file.
// Shadows take writes; a commit copies all shadows to active at once.
module pwm_duty_bank #(
    parameter int NUM_CH = 16,
    parameter int DUTY_W = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [DUTY_W-1:0]        wr_data,
    input  logic                     period_end,
    input  logic                     force_commit,
    output logic [NUM_CH*DUTY_W-1:0] shadow,
    output logic [NUM_CH*DUTY_W-1:0] duty_active,
    output logic                     commit_pending
);

    logic commit_fire;

    assign commit_fire = force_commit || (period_end && commit_pending);

    // shadow update from bus writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow[wr_ch*DUTY_W +: DUTY_W] <= wr_data;
        end
    end

    // active takes the pre-write shadow snapshot on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_active <= '0;
        end else if (commit_fire) begin
            duty_active <= shadow;
        end
    end

    // a write in the commit cycle keeps the pending flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_pending <= 1'b0;
        end else if (wr_en) begin
            commit_pending <= 1'b1;
        end else if (commit_fire) begin
            commit_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_reg_file.sv
// PWM channel register file: enables, duty shadows, CTRL and STATUS.
// Read path is built only when PWM_REG_READBACK_EN is defined.
module pwm_reg_file
    import pwm_reg_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int DUTY_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [6:0]               req_addr,
    input  logic [7:0]               req_wdata,
    input  logic                     period_end,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_rdata,
    output logic [NUM_CH-1:0]        en_out,
    output logic [NUM_CH-1:0]        en_pwm,
    output logic [NUM_CH*DUTY_W-1:0] duty_active,
    output logic                     commit_pending,
    output logic                     err
);

    localparam int NB   = NUM_CH / 8;
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [6:0] DUTY_LAST = 7'(int'(DUTY_BASE) + NUM_CH - 1);

    if (NUM_CH % 8 != 0 || NUM_CH < 8 || NUM_CH > 32) begin : g_bad_ch
        $error("NUM_CH must be 8, 16, 24 or 32");
    end
    if (DUTY_W < 1 || DUTY_W > 8) begin : g_bad_duty
        $error("DUTY_W must be in 1..8");
    end
    if (RD_LATENCY != 1) begin : g_bad_lat
        $error("read path is a single register stage");
    end

    logic              wr;
    logic              rd;
    logic [NB-1:0]     out_hit;
    logic [NB-1:0]     pwm_hit;
    logic              duty_hit;
    logic              ctrl_hit;
    logic              status_hit;
    logic              lock_span;
    logic              mapped;
    logic              wr_ok;
    logic              err_set;
    logic              err_clr;
    logic              lock_q;
    logic              force_q;
    logic [NUM_CH*DUTY_W-1:0] shadow;

    assign wr = req_valid && req_write;
    assign rd = req_valid && !req_write;

    // byte-lane decode for the enable banks
    always_comb begin
        out_hit = '0;
        pwm_hit = '0;
        for (int b = 0; b < NB; b++) begin
            out_hit[b] = (req_addr == 7'(int'(EN_OUT_BASE) + b));
            pwm_hit[b] = (req_addr == 7'(int'(EN_PWM_BASE) + b));
        end
    end

    assign duty_hit   = (req_addr >= DUTY_BASE) && (req_addr <= DUTY_LAST);
    assign ctrl_hit   = (req_addr == CTRL_ADDR);
    assign status_hit = (req_addr == STATUS_ADDR);
    assign lock_span  = (req_addr <= LOCK_SPAN_END);
    assign mapped     = (|out_hit) || (|pwm_hit) || duty_hit;

    // writes into the lockable span only land when unlocked
    assign wr_ok = wr && lock_span && !lock_q;

    // locked, unmapped, and read-only STATUS bit writes all flag an error
    assign err_set = wr && (
        (lock_span && (lock_q || !mapped)) ||
        (status_hit && req_wdata[STATUS_PEND_BIT]) ||
        (!lock_span && !ctrl_hit && !status_hit));

    assign err_clr = wr && status_hit && req_wdata[STATUS_ERR_BIT];

    // enable bytes update on the same edge the write is sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out <= '0;
            en_pwm <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (out_hit[b]) begin
                    en_out[b*8 +: 8] <= req_wdata;
                end
                if (pwm_hit[b]) begin
                    en_pwm[b*8 +: 8] <= req_wdata;
                end
            end
        end
    end

    // CTRL: lock is a plain bit, force commit is a one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q  <= 1'b0;
            force_q <= 1'b0;
        end else begin
            force_q <= wr && ctrl_hit && req_wdata[CTRL_FORCE_BIT];
            if (wr && ctrl_hit) begin
                lock_q <= req_wdata[CTRL_LOCK_BIT];
            end
        end
    end

    // sticky error, a new error beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    pwm_duty_bank #(
        .NUM_CH (NUM_CH),
        .DUTY_W (DUTY_W),
        .CH_W   (CH_W)
    ) u_bank (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_ok && duty_hit),
        .wr_ch          (req_addr[CH_W-1:0]),
        .wr_data        (req_wdata[DUTY_W-1:0]),
        .period_end     (period_end),
        .force_commit   (force_q),
        .shadow         (shadow),
        .duty_active    (duty_active),
        .commit_pending (commit_pending)
    );

`ifdef PWM_REG_READBACK_EN
    logic [7:0] rdata_next;

    // read mux, unmapped addresses fall through to zero
    always_comb begin
        rdata_next = '0;
        for (int b = 0; b < NB; b++) begin
            if (out_hit[b]) begin
                rdata_next = en_out[b*8 +: 8];
            end
            if (pwm_hit[b]) begin
                rdata_next = en_pwm[b*8 +: 8];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (req_addr == 7'(int'(DUTY_BASE) + k)) begin
                rdata_next[DUTY_W-1:0] = shadow[k*DUTY_W +: DUTY_W];
            end
        end
        if (ctrl_hit) begin
            rdata_next = ctrl_byte(lock_q);
        end
        if (status_hit) begin
            rdata_next = status_byte(err, commit_pending);
        end
    end

    // response one cycle after the read, data held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd;
            if (rd) begin
                rsp_rdata <= rdata_next;
            end
        end
    end
`else
    logic unused_rd;

    assign unused_rd = ^{rd, shadow};
    assign rsp_valid = 1'b0;
    assign rsp_rdata = '0;
`endif

endmodule

// File: tb/tb_pwm_reg_file.sv
// Self-checking bench for pwm_reg_file at default parameters.
// Read checks adapt to whether PWM_REG_READBACK_EN is defined.
module tb_pwm_reg_file;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_write = 1'b0;
    logic [6:0]   req_addr = '0;
    logic [7:0]   req_wdata = '0;
    logic         period_end = 1'b0;
    logic         rsp_valid;
    logic [7:0]   rsp_rdata;
    logic [15:0]  en_out;
    logic [15:0]  en_pwm;
    logic [127:0] duty_active;
    logic         commit_pending;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    pwm_reg_file #(
        .NUM_CH (16),
        .DUTY_W (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .period_end     (period_end),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .en_out         (en_out),
        .en_pwm         (en_pwm),
        .duty_active    (duty_active),
        .commit_pending (commit_pending),
        .err            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic w,
                         input logic [6:0] a, input logic [7:0] d,
                         input logic pe);
        @(negedge clk);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        period_end = pe;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        period_end = 1'b0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (en_out !== 16'h0 || en_pwm !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_en: got %h/%h expected 0/0", en_out, en_pwm);
        end
        n_cmp++;
        if (duty_active !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_duty: got %h expected 0", duty_active);
        end
        n_cmp++;
        if (commit_pending !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got pend=%b err=%b expected 0/0", commit_pending, err);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rsp: got %b/%h expected 0/00", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_en_write();
        wr(7'h00, 8'hA5);
        n_cmp++;
        if (en_out !== 16'h00A5) begin
            n_bad++;
            $display("FAIL en_out_b0: got %h expected 00a5", en_out);
        end
        wr(7'h01, 8'h5A);
        n_cmp++;
        if (en_out !== 16'h5AA5) begin
            n_bad++;
            $display("FAIL en_out_b1: got %h expected 5aa5", en_out);
        end
        wr(7'h11, 8'h3C);
        n_cmp++;
        if (en_pwm !== 16'h3C00 || en_out !== 16'h5AA5) begin
            n_bad++;
            $display("FAIL en_pwm_b1: got pwm=%h out=%h expected 3c00/5aa5", en_pwm, en_out);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL en_err: got %b expected 0", err);
        end
    endtask

    task automatic test_duty_commit();
        wr(7'h23, 8'h80);
        n_cmp++;
        if (duty_active[3*8 +: 8] !== 8'h00 || commit_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL duty_shadow: got ch3=%h pend=%b expected 00/1",
                     duty_active[3*8 +: 8], commit_pending);
        end
        drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
        n_cmp++;
        if (duty_active[3*8 +: 8] !== 8'h80 || commit_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL duty_commit: got ch3=%h pend=%b expected 80/0",
                     duty_active[3*8 +: 8], commit_pending);
        end
        drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
        n_cmp++;
        if (duty_active !== 128'h80 << 24 || commit_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL duty_idle_pe: got %h pend=%b expected ch3=80 only, pend 0",
                     duty_active, commit_pending);
        end
    endtask

    task automatic test_duty_coincide();
        wr(7'h20, 8'h05);
        drive(1'b1, 1'b1, 7'h20, 8'h11, 1'b1);
        n_cmp++;
        if (duty_active[7:0] !== 8'h05 || commit_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL duty_coincide: got ch0=%h pend=%b expected 05/1",
                     duty_active[7:0], commit_pending);
        end
        drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
        n_cmp++;
        if (duty_active[7:0] !== 8'h11 || commit_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL duty_coincide_next: got ch0=%h pend=%b expected 11/0",
                     duty_active[7:0], commit_pending);
        end
    endtask

    task automatic test_lock();
        wr(7'h7E, 8'h01);
        wr(7'h10, 8'hFF);
        n_cmp++;
        if (en_pwm !== 16'h3C00 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_en_pwm: got pwm=%h err=%b expected 3c00/1", en_pwm, err);
        end
        wr(7'h21, 8'h99);
        n_cmp++;
        if (commit_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_duty: got pend=%b expected 0", commit_pending);
        end
        wr(7'h7F, 8'h02);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_w1c: got err=%b expected 0", err);
        end
        wr(7'h7E, 8'h00);
        wr(7'h00, 8'hA5);
        n_cmp++;
        if (en_out !== 16'h5AA5 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL unlock: got out=%h err=%b expected 5aa5/0", en_out, err);
        end
    endtask

    task automatic test_err();
        logic [6:0] addrs[3];
        addrs = '{7'h45, 7'h7D, 7'h02};
        for (int i = 0; i < 3; i++) begin
            wr(addrs[i], 8'h77);
            n_cmp++;
            if (err !== 1'b1) begin
                n_bad++;
                $display("FAIL err_unmapped_%h: got %b expected 1", addrs[i], err);
            end
            wr(7'h7F, 8'h02);
            n_cmp++;
            if (err !== 1'b0) begin
                n_bad++;
                $display("FAIL err_clear_%h: got %b expected 0", addrs[i], err);
            end
        end
        wr(7'h7F, 8'h03);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set_wins: got %b expected 1", err);
        end
        wr(7'h7F, 8'h02);
        n_cmp++;
        if (err !== 1'b0 || en_out !== 16'h5AA5) begin
            n_bad++;
            $display("FAIL err_final: got err=%b out=%h expected 0/5aa5", err, en_out);
        end
    endtask

    task automatic test_force_commit();
        wr(7'h2F, 8'h33);
        wr(7'h7E, 8'h02);
        n_cmp++;
        if (duty_active[15*8 +: 8] !== 8'h00 || commit_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL force_early: got ch15=%h pend=%b expected 00/1",
                     duty_active[15*8 +: 8], commit_pending);
        end
        drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
        n_cmp++;
        if (duty_active[15*8 +: 8] !== 8'h33 || commit_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL force_commit: got ch15=%h pend=%b expected 33/0",
                     duty_active[15*8 +: 8], commit_pending);
        end
    endtask

    task automatic test_readback();
`ifdef PWM_REG_READBACK_EN
        logic [6:0] addrs[7];
        logic [7:0] exps[7];
        logic [7:0] e;
        wr(7'h2E, 8'h44);
        addrs = '{7'h7F, 7'h45, 7'h00, 7'h01, 7'h11, 7'h2E, 7'h7E};
        exps  = '{8'h01, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'h44, 8'h00};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exps[i]);
            drive(1'b1, 1'b0, addrs[i], 8'h00, 1'b0);
            n_cmp++;
            if (rsp_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL rd_valid_%h: got %b expected 1", addrs[i], rsp_valid);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rsp_rdata !== e) begin
                    n_bad++;
                    $display("FAIL rd_data_%h: got %h expected %h", addrs[i], rsp_rdata, e);
                end
            end
        end
        drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_idle: got v=%b d=%h err=%b expected 0/00/0",
                     rsp_valid, rsp_rdata, err);
        end
`else
        drive(1'b1, 1'b0, 7'h7F, 8'h00, 1'b0);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL rd_disabled: got %b/%h expected 0/00", rsp_valid, rsp_rdata);
        end
        wr(7'h2E, 8'h44);
        n_cmp++;
        if (commit_pending !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_disabled_wr: got pend=%b err=%b expected 1/0",
                     commit_pending, err);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        wr(7'h2F, 8'h55);
        wr(7'h7E, 8'h02);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (commit_pending !== 1'b0 || duty_active !== 128'h0) begin
            n_bad++;
            $display("FAIL rst_async: got pend=%b duty=%h expected 0/0",
                     commit_pending, duty_active);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
        n_cmp++;
        if (duty_active[15*8 +: 8] !== 8'h00 || commit_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_force_drop: got ch15=%h pend=%b expected 00/0",
                     duty_active[15*8 +: 8], commit_pending);
        end
`ifdef PWM_REG_READBACK_EN
        drive(1'b1, 1'b0, 7'h00, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_rsp_async: got %b expected 0", rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
            n_cmp++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
                n_bad++;
                $display("FAIL rst_no_rsp_%0d: got %b/%h expected 0/00",
                         i, rsp_valid, rsp_rdata);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_en_write();
        test_duty_commit();
        test_duty_coincide();
        test_lock();
        test_err();
        test_force_commit();
        test_readback();
        test_reset_midflight();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
